// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU multiplier arbiter and later FPU-unit arbiters.
package fpu_pkg;

  // IEEE-754 single-precision field widths
  localparam int FP32_SIGN_W = 1;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int FP32_W      = FP32_SIGN_W + FP32_EXP_W + FP32_FRAC_W;

  // Multiplier mode encoding
  localparam logic MODE_FP32 = 1'b0;
  localparam logic MODE_FP16 = 1'b1;

  // Arbiter sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } arb_state_e;

endpackage

// File: rtl/fpu_mul_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around. Produces one-hot grant, its index and a valid.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int   w_pos;
  logic w_found;

  // Scan from the pointer upward; the first hit wins and later hits are ignored
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
      end else begin
        w_found = w_found;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one FP multiplier between NUM_REQ
// requesters. One operation in flight: grant, issue start pulse, wait for
// done (ignoring a stale done on entry), ack the owner, drain done.
import fpu_pkg::*;

module fpu_mul_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64,
  parameter int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*FP32_W-1:0] i_op_a,
  input  logic [NUM_REQ*FP32_W-1:0] i_op_b,
  input  logic [NUM_REQ-1:0]        i_op_mode,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [FP32_W-1:0]         o_result,
  output logic                      o_err,
  output logic                      o_busy,
  output logic [IDX_W-1:0]          o_grant_idx,
  output logic [FP32_W-1:0]         o_mul_a,
  output logic [FP32_W-1:0]         o_mul_b,
  output logic                      o_mul_mode,
  output logic                      o_mul_start,
  input  logic [FP32_W-1:0]         i_mul_product,
  input  logic                      i_mul_done
);

  // Counter shared by ISSUE, WAIT and DRAIN; sized for the longest phase
  localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0]  r_owner_oh;
  logic [NUM_REQ-1:0]  r_ack;
  logic [FP32_W-1:0]   r_result;
  logic                r_err;
  logic                r_busy;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [FP32_W-1:0]   r_mul_a;
  logic [FP32_W-1:0]   r_mul_b;
  logic                r_mul_mode;
  logic                r_mul_start;

  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_valid;
  logic [IDX_W-1:0]    w_ptr_next;
  logic [FP32_W-1:0]   w_sel_a;
  logic [FP32_W-1:0]   w_sel_b;
  logic                w_sel_mode;
  logic                w_wait_last;
  logic                w_drain_last;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Winner's operands and the pointer just past the winner
  assign w_sel_a      = i_op_a[int'(w_pick_idx)*FP32_W +: FP32_W];
  assign w_sel_b      = i_op_b[int'(w_pick_idx)*FP32_W +: FP32_W];
  assign w_sel_mode   = i_op_mode[w_pick_idx];
  assign w_ptr_next   = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : (w_pick_idx + IDX_W'(1));
  assign w_wait_last  = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_drain_last = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Sequencer: grant, start pulse, done/timeout wait, ack, done drain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_owner_oh  <= '0;
      r_ack       <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_grant_idx <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_mode  <= MODE_FP32;
      r_mul_start <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant_idx <= w_pick_idx;
            r_owner_oh  <= w_pick_oh;
            r_ptr       <= w_ptr_next;
            r_mul_a     <= w_sel_a;
            r_mul_b     <= w_sel_b;
            r_mul_mode  <= w_sel_mode;
            r_mul_start <= 1'b1;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ISSUE;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ISSUE: begin
          if (r_cnt == CNT_W'(START_CYCLES - 1)) begin
            r_mul_start <= 1'b0;
            r_cnt       <= '0;
            r_state     <= WAIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          // r_cnt == 0 is the first WAIT cycle: a done seen there is stale
          if ((r_cnt != '0) && i_mul_done) begin
            r_result <= i_mul_product;
            r_err    <= 1'b0;
            r_ack    <= r_owner_oh;
            r_cnt    <= '0;
            r_state  <= RESP;
          end else if (w_wait_last) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_ack    <= r_owner_oh;
            r_cnt    <= '0;
            r_state  <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          // After a timeout there is nothing to drain
          if (r_err) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt   <= '0;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!i_mul_done || w_drain_last) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_busy      <= 1'b0;
          r_mul_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_result    = r_result;
  assign o_err       = r_err;
  assign o_busy      = r_busy;
  assign o_grant_idx = r_grant_idx;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_mul_mode  = r_mul_mode;
  assign o_mul_start = r_mul_start;

endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one `multiplier` instance (32-bit / 16-bit mode FP multiplier with start/done handshake) between NUM_REQ requesters. It captures the winning requester's operands and drives the multiplier's start/mode/operands. It then waits for done, returns the Product to that requester with a one-cycle ack, and waits for done to drop before re-arming. It sits between the FPU issue logic and the multiplier datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_CYCLES, 2, cycles mul_start is held high per operation (>=1)
TIMEOUT, 64, max cycles to wait for mul_done (rise or fall) before aborting with err
IDX_W, $clog2(NUM_REQ), width of granted-index output

Ports:
Clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  request per requester; held high with operands stable until ack
op_a  input  NUM_REQ*32  packed operand A, requester i at [32*i+31:32*i]
op_b  input  NUM_REQ*32  packed operand B, same packing
op_mode  input  NUM_REQ  per-requester mode (0 = 32-bit, 1 = 16-bit)
ack  output  NUM_REQ  one-hot, one-cycle pulse: result/err valid for that requester
result  output  32  product for the acked requester, valid while ack != 0
err  output  1  timeout flag, valid while ack != 0
busy  output  1  high from grant until return to IDLE
grant_idx  output  IDX_W  index of current owner, valid while busy
mul_A  output  32  to multiplier A
mul_B  output  32  to multiplier B
mul_mode  output  1  to multiplier mode
mul_start  output  1  to multiplier start
mul_Product  input  32  from multiplier Product
mul_done  input  1  from multiplier done

Behaviour:
- Reset (reset=0, async): state=IDLE; ack=0, result=0, err=0, busy=0, grant_idx=0, mul_A=0, mul_B=0, mul_mode=0, mul_start=0; rr pointer=0; counters=0. Reset mid-operation aborts silently: no ack is issued and the multiplier sees start drop immediately.
- IDLE: if any req, pick the first set bit searching from rr pointer upward with wrap. Latch op_a/op_b/op_mode of the winner into mul_A/mul_B/mul_mode. Set grant_idx, busy=1, and rr pointer = winner+1 mod NUM_REQ. Go to ISSUE. Grant happens in the cycle after req is seen.
- ISSUE: mul_start=1 for exactly START_CYCLES cycles, then go to WAIT. Operand outputs are stable from ISSUE through DRAIN.
- WAIT: count cycles. If mul_done=1, register mul_Product into result and go to RESP with err=0. If the count reaches TIMEOUT, go to RESP with err=1 and result=0.
- RESP: ack[grant_idx]=1 for one cycle. If err, go directly to IDLE; otherwise go to DRAIN.
- DRAIN: wait for mul_done=0, then go to IDLE with busy=0. If it has not dropped after TIMEOUT cycles, return to IDLE anyway (error already reported is not repeated).
- mul_done already high on entry to WAIT (stale) is ignored: WAIT samples only from its second cycle.
- Minimum latency from req to ack = 1 (grant) + START_CYCLES + 1 (first WAIT sample) + 1 (RESP) cycles.
- req dropped by a requester before ack: the operation completes and ack is still pulsed. The requester must ignore it; no data is corrupted.
- Requests that are not granted are held pending with no queueing. A requester re-asserting req right after ack competes normally under round-robin, so no starvation.
- Only one operation is in flight at a time; back-to-back grants have no bubble beyond DRAIN→IDLE→grant.

Decomposition:
- Package fpu_pkg: state enum {IDLE, ISSUE, WAIT, RESP, DRAIN}, MODE_FP32=0 and MODE_FP16=1 constants, and FP32 field widths (sign 1, exp 8, frac 23).
- Sub-module rr_picker: combinational round-robin priority picker (req vector + pointer → one-hot grant + index + valid). It is reused by later FPU-unit arbiters.

Test Plan:
- Single request: req=0001, op_a=0x40400000 (3.0), op_b=0x40000000 (2.0), mode=0, model multiplier done after 5 cycles returning 0x40C00000 → ack=0001 for one cycle, result=0x40C00000, err=0; mul_start high exactly 2 cycles.
- Contention: req=1111 held continuously, pointer=0 after reset → grant order 0,1,2,3,0; each ack one-hot; exactly one operation in flight.
- Timeout: model never raises mul_done, TIMEOUT=64 → ack after 64 WAIT cycles with err=1, result=0, then IDLE; next request is serviced normally.
- Stale done: model holds done high through the next grant for 1 extra cycle → no premature ack; DRAIN holds until done=0.
- Reset mid-operation: assert reset in WAIT → all outputs return to 0 asynchronously, no ack; after release, a new req=0100 is granted at index 2 (pointer reset to 0 searching upward).
- Mode pass-through: req=0010 with op_mode[1]=1 → mul_mode=1 throughout ISSUE..DRAIN, grant_idx=1.
